// File: rtl/reservation_station.sv
// ALU reservation station: buffers renamed ALU-class instructions, captures
// operands from the ALU/LSB broadcasts and dispatches one ready entry per cycle.
module reservation_station #(
    parameter int RS_SIZE  = 16,
    parameter int RS_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        issue,
    input  logic        rs_en,
    input  logic [3:0]  rob_pos,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic [31:0] rs1_val,
    input  logic [4:0]  rs1_rob_id,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rs2_rob_id,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic        rs_nxt_full,
    output logic        alu_en,
    output logic [6:0]  alu_opcode,
    output logic [2:0]  alu_funct3,
    output logic        alu_funct7,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    output logic [3:0]  alu_rob_pos,
    input  logic        alu_result,
    input  logic [3:0]  alu_result_rob_pos,
    input  logic [31:0] alu_result_val,
    input  logic        lsb_result,
    input  logic [3:0]  lsb_result_rob_pos,
    input  logic [31:0] lsb_result_val
);

    localparam logic [RS_IDX_W+1:0] FULL_LVL = (RS_IDX_W + 2)'(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [6:0]         opcode_q [RS_SIZE];
    logic [6:0]         opcode_d [RS_SIZE];
    logic [2:0]         funct3_q [RS_SIZE];
    logic [2:0]         funct3_d [RS_SIZE];
    logic               funct7_q [RS_SIZE];
    logic               funct7_d [RS_SIZE];
    logic [4:0]         q1_q     [RS_SIZE];
    logic [4:0]         q1_d     [RS_SIZE];
    logic [4:0]         q2_q     [RS_SIZE];
    logic [4:0]         q2_d     [RS_SIZE];
    logic [31:0]        v1_q     [RS_SIZE];
    logic [31:0]        v1_d     [RS_SIZE];
    logic [31:0]        v2_q     [RS_SIZE];
    logic [31:0]        v2_d     [RS_SIZE];
    logic [31:0]        imm_q    [RS_SIZE];
    logic [31:0]        imm_d    [RS_SIZE];
    logic [31:0]        pc_q     [RS_SIZE];
    logic [31:0]        pc_d     [RS_SIZE];
    logic [3:0]         robpos_q [RS_SIZE];
    logic [3:0]         robpos_d [RS_SIZE];

    logic                free_found, sel_found, ins;
    logic [RS_IDX_W-1:0] free_idx, sel_idx;
    logic [RS_IDX_W:0]   busy_count;
    logic [RS_IDX_W+1:0] fill_lvl;

    // A pending tag takes the broadcast value; the ALU broadcast has priority.
    function automatic logic [36:0] resolve(input logic [4:0] q, input logic [31:0] v);
        if (q[4] && alu_result && q[3:0] == alu_result_rob_pos)
            return {5'b0, alu_result_val};
        else if (q[4] && lsb_result && q[3:0] == lsb_result_rob_pos)
            return {5'b0, lsb_result_val};
        return {q, v};
    endfunction

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        busy_count = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            busy_count = busy_count + (RS_IDX_W + 1)'(busy_q[i]);
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_W'(i);
            end
            if (busy_q[i] && !q1_q[i][4] && !q2_q[i][4]) begin
                sel_found = 1'b1;
                sel_idx   = RS_IDX_W'(i);
            end
        end
        ins      = issue && rs_en && free_found;
        fill_lvl = {1'b0, busy_count} + (RS_IDX_W + 2)'(issue && rs_en);
    end

    assign rs_nxt_full = (fill_lvl >= FULL_LVL);

    always_comb begin
        busy_d = busy_q;
        if (ins)
            busy_d[free_idx] = 1'b1;
        if (sel_found)
            busy_d[sel_idx] = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            opcode_d[i] = opcode_q[i];
            funct3_d[i] = funct3_q[i];
            funct7_d[i] = funct7_q[i];
            q1_d[i]     = q1_q[i];
            q2_d[i]     = q2_q[i];
            v1_d[i]     = v1_q[i];
            v2_d[i]     = v2_q[i];
            imm_d[i]    = imm_q[i];
            pc_d[i]     = pc_q[i];
            robpos_d[i] = robpos_q[i];
            if (busy_q[i]) begin
                {q1_d[i], v1_d[i]} = resolve(q1_q[i], v1_q[i]);
                {q2_d[i], v2_d[i]} = resolve(q2_q[i], v2_q[i]);
            end
            if (ins && free_idx == RS_IDX_W'(i)) begin
                opcode_d[i]        = opcode;
                funct3_d[i]        = funct3;
                funct7_d[i]        = funct7;
                {q1_d[i], v1_d[i]} = resolve(rs1_rob_id, rs1_val);
                {q2_d[i], v2_d[i]} = resolve(rs2_rob_id, rs2_val);
                imm_d[i]           = imm;
                pc_d[i]            = pc;
                robpos_d[i]        = rob_pos;
            end
        end
    end

    // Entry payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rdy && !rollback) begin
            opcode_q <= opcode_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            q1_q     <= q1_d;
            q2_q     <= q2_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            robpos_q <= robpos_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rollback) begin
            busy_q <= '0;
            alu_en <= 1'b0;
        end else if (rdy) begin
            busy_q <= busy_d;
            alu_en <= sel_found;
            if (sel_found) begin
                alu_opcode  <= opcode_q[sel_idx];
                alu_funct3  <= funct3_q[sel_idx];
                alu_funct7  <= funct7_q[sel_idx];
                alu_val1    <= v1_q[sel_idx];
                alu_val2    <= v2_q[sel_idx];
                alu_imm     <= imm_q[sel_idx];
                alu_pc      <= pc_q[sel_idx];
                alu_rob_pos <= robpos_q[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: insert, wakeup, capture, fill,
// rollback, freeze and asynchronous reset scenarios.
module tb_reservation_station;

    logic        clk, rst, rdy, rollback, issue, rs_en;
    logic [3:0]  rob_pos;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] rs1_val, rs2_val, imm, pc;
    logic [4:0]  rs1_rob_id, rs2_rob_id;
    logic        rs_nxt_full, alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;
    logic        alu_result, lsb_result;
    logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
    logic [31:0] alu_result_val, lsb_result_val;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue(issue), .rs_en(rs_en), .rob_pos(rob_pos), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rs1_val(rs1_val),
        .rs1_rob_id(rs1_rob_id), .rs2_val(rs2_val), .rs2_rob_id(rs2_rob_id),
        .imm(imm), .pc(pc), .rs_nxt_full(rs_nxt_full), .alu_en(alu_en),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos), .alu_result(alu_result),
        .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
        .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
        .lsb_result_val(lsb_result_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rollback = 0; issue = 0; rs_en = 0; rob_pos = 0; opcode = 0;
        funct3 = 0; funct7 = 0; rs1_val = 0; rs1_rob_id = 0; rs2_val = 0;
        rs2_rob_id = 0; imm = 0; pc = 0;
        alu_result = 0; alu_result_rob_pos = 0; alu_result_val = 0;
        lsb_result = 0; lsb_result_rob_pos = 0; lsb_result_val = 0;
    endtask

    task automatic set_issue(input logic [6:0] op, input logic [3:0] rp,
                             input logic [4:0] q1, input logic [31:0] v1,
                             input logic [4:0] q2, input logic [31:0] v2,
                             input logic [31:0] im, input logic [31:0] p);
        issue = 1; rs_en = 1; opcode = op; funct3 = 3'd0; funct7 = 1'b0;
        rob_pos = rp; rs1_rob_id = q1; rs1_val = v1; rs2_rob_id = q2;
        rs2_val = v2; imm = im; pc = p;
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1;
        clear_inputs();
        step();
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL reset_alu_en got=%0b exp=0", alu_en); end
        total++; if (alu_val1 !== 32'h0) begin bad++; $display("FAIL reset_val1 got=%0h exp=0", alu_val1); end
        total++; if (alu_rob_pos !== 4'h0) begin bad++; $display("FAIL reset_rob_pos got=%0h exp=0", alu_rob_pos); end
        total++; if (rs_nxt_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", rs_nxt_full); end
        rst = 0;
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL post_reset_alu_en got=%0b exp=0", alu_en); end
    endtask

    task automatic test_ready_op();
        set_issue(OP_ADDI, 4'd2, 5'h00, 32'd5, 5'h00, 32'd0, 32'd3, 32'h100);
        step();
        clear_inputs();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL ready_same_edge got=%0b exp=0", alu_en); end
        step();
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL ready_en got=%0b exp=1", alu_en); end
        total++; if (alu_val1 !== 32'd5) begin bad++; $display("FAIL ready_val1 got=%0h exp=5", alu_val1); end
        total++; if (alu_imm !== 32'd3) begin bad++; $display("FAIL ready_imm got=%0h exp=3", alu_imm); end
        total++; if (alu_rob_pos !== 4'd2) begin bad++; $display("FAIL ready_rob got=%0h exp=2", alu_rob_pos); end
        total++; if (alu_opcode !== OP_ADDI) begin bad++; $display("FAIL ready_opcode got=%0h exp=%0h", alu_opcode, OP_ADDI); end
        total++; if (alu_pc !== 32'h100) begin bad++; $display("FAIL ready_pc got=%0h exp=100", alu_pc); end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL ready_drop got=%0b exp=0", alu_en); end
    endtask

    task automatic test_wakeup();
        set_issue(OP_ADD, 4'd5, 5'h13, 32'hDEAD, 5'h00, 32'd7, 32'd0, 32'h200);
        step();
        clear_inputs();
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_early got=%0b exp=0", alu_en); end
        alu_result = 1; alu_result_rob_pos = 4'd3; alu_result_val = 32'h77;
        step();
        clear_inputs();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_same_edge got=%0b exp=0", alu_en); end
        step();
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL wake_en got=%0b exp=1", alu_en); end
        total++; if (alu_val1 !== 32'h77) begin bad++; $display("FAIL wake_val1 got=%0h exp=77", alu_val1); end
        total++; if (alu_val2 !== 32'd7) begin bad++; $display("FAIL wake_val2 got=%0h exp=7", alu_val2); end
        total++; if (alu_rob_pos !== 4'd5) begin bad++; $display("FAIL wake_rob got=%0h exp=5", alu_rob_pos); end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_drop got=%0b exp=0", alu_en); end
    endtask

    task automatic test_capture();
        set_issue(OP_ADD, 4'd6, 5'h00, 32'd1, 5'h14, 32'hDEAD, 32'd0, 32'h300);
        lsb_result = 1; lsb_result_rob_pos = 4'd4; lsb_result_val = 32'hAB;
        step();
        clear_inputs();
        step();
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL cap_en got=%0b exp=1", alu_en); end
        total++; if (alu_val2 !== 32'hAB) begin bad++; $display("FAIL cap_val2 got=%0h exp=ab", alu_val2); end
        // Both broadcasts hit the same tag: the ALU value must be taken.
        set_issue(OP_ADD, 4'd7, 5'h00, 32'd1, 5'h14, 32'hDEAD, 32'd0, 32'h304);
        alu_result = 1; alu_result_rob_pos = 4'd4; alu_result_val = 32'h11;
        lsb_result = 1; lsb_result_rob_pos = 4'd4; lsb_result_val = 32'h22;
        step();
        clear_inputs();
        step();
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL cap2_en got=%0b exp=1", alu_en); end
        total++; if (alu_val2 !== 32'h11) begin bad++; $display("FAIL cap2_alu_wins got=%0h exp=11", alu_val2); end
        step();
    endtask

    task automatic test_ignored_broadcasts();
        set_issue(OP_ADD, 4'd8, 5'h18, 32'd0, 5'h00, 32'd2, 32'd0, 32'h400);
        step();
        clear_inputs();
        alu_result = 0; alu_result_rob_pos = 4'd8; alu_result_val = 32'h5;
        lsb_result = 1; lsb_result_rob_pos = 4'd7; lsb_result_val = 32'h6;
        step();
        clear_inputs();
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL ign_no_wake got=%0b exp=0", alu_en); end
        lsb_result = 1; lsb_result_rob_pos = 4'd8; lsb_result_val = 32'h88;
        step();
        clear_inputs();
        step();
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL ign_wake_en got=%0b exp=1", alu_en); end
        total++; if (alu_val1 !== 32'h88) begin bad++; $display("FAIL ign_wake_val got=%0h exp=88", alu_val1); end
        step();
    endtask

    task automatic test_fill();
        int pulses;
        for (int i = 0; i < 16; i++) begin
            set_issue(OP_ADD, 4'(i), 5'h19, 32'd0, 5'h00, 32'(i), 32'd0, 32'h1000 + 32'(i));
            #1;
            total++;
            if (rs_nxt_full !== (i == 15)) begin
                bad++; $display("FAIL fill_full_%0d got=%0b exp=%0b", i, rs_nxt_full, (i == 15));
            end
            step();
        end
        clear_inputs();
        #1;
        total++; if (rs_nxt_full !== 1'b1) begin bad++; $display("FAIL fill_full_idle got=%0b exp=1", rs_nxt_full); end
        // A ready instruction issued into a full station must be dropped.
        set_issue(OP_ADDI, 4'd15, 5'h00, 32'h55, 5'h00, 32'd0, 32'd0, 32'h2000);
        step();
        clear_inputs();
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL fill_drop got=%0b exp=0", alu_en); end
        alu_result = 1; alu_result_rob_pos = 4'd9; alu_result_val = 32'h99;
        step();
        clear_inputs();
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (alu_en === 1'b1) begin
                total++;
                if (alu_rob_pos !== 4'(pulses) || alu_val1 !== 32'h99) begin
                    bad++; $display("FAIL fill_order_%0d got=%0h/%0h exp=%0h/99", pulses, alu_rob_pos, alu_val1, pulses);
                end
                pulses++;
            end
        end
        total++; if (pulses !== 16) begin bad++; $display("FAIL fill_pulses got=%0d exp=16", pulses); end
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 3; i++) begin
            set_issue(OP_ADD, 4'(i), 5'h1A, 32'd0, 5'h00, 32'd0, 32'd0, 32'h3000);
            step();
        end
        set_issue(OP_ADDI, 4'd3, 5'h00, 32'd9, 5'h00, 32'd0, 32'd0, 32'h3004);
        step();
        set_issue(OP_ADDI, 4'd4, 5'h00, 32'd9, 5'h00, 32'd0, 32'd0, 32'h3008);
        rollback = 1;
        alu_result = 1; alu_result_rob_pos = 4'd10; alu_result_val = 32'hAA;
        step();
        clear_inputs();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL rb_en got=%0b exp=0", alu_en); end
        total++; if (rs_nxt_full !== 1'b0) begin bad++; $display("FAIL rb_full got=%0b exp=0", rs_nxt_full); end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL rb_issue_dropped got=%0b exp=0", alu_en); end
        alu_result = 1; alu_result_rob_pos = 4'd10; alu_result_val = 32'hAA;
        step();
        clear_inputs();
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL rb_late_wake got=%0b exp=0", alu_en); end
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL rb_late_wake2 got=%0b exp=0", alu_en); end
    endtask

    task automatic test_rdy_and_async_reset();
        set_issue(OP_ADDI, 4'd7, 5'h00, 32'h3C, 5'h00, 32'd0, 32'd0, 32'h4000);
        step();
        set_issue(OP_ADDI, 4'd8, 5'h00, 32'h4D, 5'h00, 32'd0, 32'd0, 32'h4004);
        step();
        clear_inputs();
        total++; if (alu_en !== 1'b1 || alu_rob_pos !== 4'd7) begin bad++; $display("FAIL rdy_first got=%0b/%0h exp=1/7", alu_en, alu_rob_pos); end
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (alu_en !== 1'b1 || alu_rob_pos !== 4'd7) begin
                bad++; $display("FAIL rdy_hold_%0d got=%0b/%0h exp=1/7", i, alu_en, alu_rob_pos);
            end
        end
        rdy = 1;
        step();
        total++; if (alu_en !== 1'b1 || alu_rob_pos !== 4'd8) begin bad++; $display("FAIL rdy_resume got=%0b/%0h exp=1/8", alu_en, alu_rob_pos); end
        total++; if (alu_val1 !== 32'h4D) begin bad++; $display("FAIL rdy_resume_val got=%0h exp=4d", alu_val1); end
        rst = 1;
        #1;
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL async_rst_en got=%0b exp=0", alu_en); end
        total++; if (alu_rob_pos !== 4'd0) begin bad++; $display("FAIL async_rst_rob got=%0h exp=0", alu_rob_pos); end
        #1;
        rst = 0;
        step();
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL post_async_en got=%0b exp=0", alu_en); end
    endtask

    initial begin
        test_reset();
        test_ready_op();
        test_wakeup();
        test_capture();
        test_ignored_broadcasts();
        test_fill();
        test_rollback();
        test_rdy_and_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
